// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with ack/timeout reporting
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   tx_data, tx_start     command byte and one-cycle request (taken only when idle)
//   tx_busy               transaction in progress
//   tx_done, tx_error     end-of-transaction pulse; error = NACK or timeout
//   ps2_clk_in/data_in    raw open-drain line levels
//   ps2_clk_out/data_out  0 = pull line low, 1 = release
//   ps2_dir               1 while the host owns the bus
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    output logic       ps2_dir
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
    } state_t;

    // Input conditioning: 2-flop synchronizer, then a level is accepted only
    // after FILTER_LEN identical synchronized samples.
    logic [1:0]            clk_sync_q, data_sync_q;
    logic [FILTER_LEN-1:0] clk_hist_q, data_hist_q;
    logic                  clk_filt_q, data_filt_q;
    logic                  clk_filt_d, data_filt_d;
    logic                  fall;

    always_comb begin
        clk_filt_d  = clk_filt_q;
        data_filt_d = data_filt_q;
        if (&clk_hist_q)       clk_filt_d  = 1'b1;
        else if (~|clk_hist_q) clk_filt_d  = 1'b0;
        if (&data_hist_q)       data_filt_d = 1'b1;
        else if (~|data_hist_q) data_filt_d = 1'b0;
    end

    // Fall is flagged the cycle the filter commits to 0, so the FSM acts on
    // it at the same edge the filtered level updates.
    assign fall = clk_filt_q & ~clk_filt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_hist_q  <= '1;
            data_hist_q <= '1;
            clk_filt_q  <= 1'b1;
            data_filt_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_hist_q  <= FILTER_LEN'({clk_hist_q, clk_sync_q[1]});
            data_hist_q <= FILTER_LEN'({data_hist_q, data_sync_q[1]});
            clk_filt_q  <= clk_filt_d;
            data_filt_q <= data_filt_d;
        end
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [9:0]    frame_q, frame_d;      // {stop, parity, data}; start bit is driven in REQ
    logic          nack_q, nack_d;
    logic          clk_out_q, clk_out_d;
    logic          data_out_q, data_out_d;
    logic          dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          timed_out;

    assign timed_out = (state_q inside {S_SEND, S_ACK, S_WAIT_IDLE}) && (cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        frame_d    = frame_q;
        nack_d     = nack_q;
        clk_out_d  = clk_out_q;
        data_out_d = data_out_q;
        dir_d      = dir_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is dropped on purpose.
                if (tx_start && !done_q) begin
                    state_d    = S_INHIBIT;
                    frame_d    = {1'b1, ~^tx_data, tx_data};
                    cnt_d      = '0;
                    clk_out_d  = 1'b0;
                    data_out_d = 1'b1;
                    dir_d      = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d    = S_REQ;
                    data_out_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                state_d   = S_SEND;
                clk_out_d = 1'b1;
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            S_SEND: begin
                cnt_d = cnt_q + 1'b1;
                if (fall) begin
                    data_out_d = frame_q[bit_idx_q];
                    if (bit_idx_q != 4'hF) bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 4'd9) state_d = S_ACK;
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + 1'b1;
                if (fall) begin
                    nack_d  = data_filt_q;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = cnt_q + 1'b1;
                if (clk_filt_q && data_filt_q) begin
                    state_d    = S_IDLE;
                    clk_out_d  = 1'b1;
                    data_out_d = 1'b1;
                    dir_d      = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    err_d      = nack_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timed_out) begin
            state_d    = S_IDLE;
            clk_out_d  = 1'b1;
            data_out_d = 1'b1;
            dir_d      = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            err_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            frame_q    <= '1;
            nack_q     <= 1'b0;
            clk_out_q  <= 1'b1;
            data_out_q <= 1'b1;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            nack_q     <= nack_d;
            clk_out_q  <= clk_out_d;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx_busy      = busy_q;
    assign tx_done      = done_q;
    assign tx_error     = err_q;
    assign ps2_clk_out  = clk_out_q;
    assign ps2_data_out = data_out_q;
    assign ps2_dir      = dir_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TO  = 2000;
    localparam int FL  = 2;
    localparam int NV  = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_out, ps2_data_out, ps2_dir;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Open-drain bus: either side may pull a line low.
    assign ps2_clk_in  = ps2_clk_out & dev_clk;
    assign ps2_data_in = ps2_data_out & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN(FL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_out(ps2_clk_out),
        .ps2_data_out(ps2_data_out),
        .ps2_dir(ps2_dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (tx_done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_err;
    } vec_t;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference frame as the device should see it: data LSB first, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    task automatic start_tx(input logic [7:0] b, input string tag);
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check({tag, "_start_busy"}, tx_busy, 1);
        check({tag, "_start_dir"}, ps2_dir, 1);
        check({tag, "_start_clk_low"}, ps2_clk_out, 0);
    endtask

    task automatic measure_inhibit(input string tag);
        int lo, inh;
        lo = 0;
        inh = 0;
        while (ps2_clk_out === 1'b0 && lo < 100) begin
            lo++;
            if (ps2_data_out === 1'b1) inh++;
            tick();
        end
        check({tag, "_clk_low_total"}, lo, INH + 1);
        check({tag, "_inhibit_len"}, inh, INH);
    endtask

    // Device: 11 clock pulses of 40 clks; samples data on each rise 1..10,
    // pulls data low ahead of fall 11 to acknowledge.
    task automatic device(input bit do_ack, input int inject_fall, input int abort_fall,
                          output logic [9:0] bits, output bit busy_ok);
        int t;
        bits = '1;
        busy_ok = 1'b1;
        t = 0;
        while (!(ps2_clk_out === 1'b1 && ps2_data_out === 1'b0) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            check("dev_request_wait", 0, 1);
            busy_ok = 1'b0;
            return;
        end
        repeat (10) tick();
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            if (i == abort_fall) return;
            for (int k = 0; k < 20; k++) begin
                if (i == inject_fall && k == 0) begin
                    tx_data  = 8'h55;
                    tx_start = 1'b1;
                end else begin
                    tx_start = 1'b0;
                end
                tick();
                if (tx_busy !== 1'b1) busy_ok = 1'b0;
            end
            tx_start = 1'b0;
            dev_clk = 1'b1;
            if (i == 11) begin
                dev_data = 1'b1;
                return;
            end
            bits[i-1] = ps2_data_in;
            for (int k = 0; k < 20; k++) begin
                if (i == 10 && k == 10 && do_ack) dev_data = 1'b0;
                tick();
                if (tx_busy !== 1'b1) busy_ok = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int cyc;
        cyc = 0;
        while (tx_done !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
        check({tag, "_done_seen"}, tx_done, 1);
    endtask

    task automatic post_idle(input string tag, input bit exp_err);
        check({tag, "_error"}, tx_error, exp_err);
        tick();
        check({tag, "_post_busy"}, tx_busy, 0);
        check({tag, "_post_dir"}, ps2_dir, 0);
        check({tag, "_post_clk"}, ps2_clk_out, 1);
        check({tag, "_post_data"}, ps2_data_out, 1);
        check({tag, "_post_done_pulse"}, tx_done, 0);
        check({tag, "_post_error_held"}, tx_error, exp_err);
    endtask

    task automatic full_frame(input logic [7:0] b, input bit ack, input bit exp_err,
                              input int inject_fall, input string tag);
        logic [9:0] bits;
        bit         bok;
        start_tx(b, tag);
        measure_inhibit(tag);
        device(ack, inject_fall, 0, bits, bok);
        check({tag, "_frame_bits"}, bits, model_frame(b));
        check({tag, "_busy_held"}, bok, 1);
        wait_done(tag, 400);
        post_idle(tag, exp_err);
    endtask

    initial begin
        vec_t       vecs[NV];
        int         dc, k;
        bit         busy_seen;
        logic [9:0] bits;
        bit         bok;

        vecs[0] = '{data: 8'hF4, ack: 1'b1, exp_err: 1'b0};
        vecs[1] = '{data: 8'h00, ack: 1'b1, exp_err: 1'b0};
        vecs[2] = '{data: 8'hFF, ack: 1'b0, exp_err: 1'b1};
        for (int i = 3; i < NV; i++) begin
            vecs[i].data    = 8'($urandom_range(0, 255));
            vecs[i].ack     = 1'($urandom_range(0, 1));
            vecs[i].exp_err = !vecs[i].ack;
        end

        repeat (3) tick();
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        check("rst_clk_out", ps2_clk_out, 1);
        check("rst_data_out", ps2_data_out, 1);
        check("rst_dir", ps2_dir, 0);
        reset = 1'b0;
        repeat (3) tick();

        for (int v = 0; v < NV; v++) begin
            full_frame(vecs[v].data, vecs[v].ack, vecs[v].exp_err, 0, $sformatf("vec%0d", v));
            repeat (5) tick();
        end

        // Device never clocks: timeout counted from clock release.
        start_tx(8'h3C, "timeout");
        measure_inhibit("timeout");
        k = 0;
        while (tx_done !== 1'b1 && k < 2500) begin
            tick();
            k++;
        end
        check("timeout_done_seen", tx_done, 1);
        check_range("timeout_cycles", k, TO - 1, TO + 1);
        post_idle("timeout", 1'b1);
        repeat (5) tick();

        // Second start in the middle of a transfer must be ignored.
        full_frame(8'hF4, 1'b1, 1'b0, 3, "midstart");
        dc = done_cnt;
        busy_seen = 1'b0;
        repeat (60) begin
            tick();
            if (tx_busy !== 1'b0) busy_seen = 1'b1;
        end
        check("midstart_no_second_busy", busy_seen, 0);
        check("midstart_no_second_done", done_cnt - dc, 0);

        // Start held through the done pulse: dropped in the done cycle, taken one cycle later.
        start_tx(8'hA5, "b2b");
        measure_inhibit("b2b");
        device(1'b1, 0, 0, bits, bok);
        check("b2b_frame_bits", bits, model_frame(8'hA5));
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        wait_done("b2b", 400);
        check("b2b_error", tx_error, 0);
        tick();
        check("b2b_start_at_done_ignored", tx_busy, 0);
        tick();
        tx_start = 1'b0;
        check("b2b_next_start_taken", tx_busy, 1);
        measure_inhibit("b2b2");
        device(1'b1, 0, 0, bits, bok);
        check("b2b2_frame_bits", bits, model_frame(8'h3C));
        wait_done("b2b2", 400);
        post_idle("b2b2", 1'b0);
        repeat (5) tick();

        // Reset just after fall 5.
        start_tx(8'h5A, "rstmid");
        measure_inhibit("rstmid");
        device(1'b1, 0, 5, bits, bok);
        repeat (8) tick();
        dc = done_cnt;
        reset = 1'b1;
        dev_clk = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_busy", tx_busy, 0);
        check("rstmid_done", tx_done, 0);
        check("rstmid_error", tx_error, 0);
        check("rstmid_clk_out", ps2_clk_out, 1);
        check("rstmid_data_out", ps2_data_out, 1);
        check("rstmid_dir", ps2_dir, 0);
        repeat (30) tick();
        check("rstmid_no_done", done_cnt - dc, 0);
        full_frame(8'hF2, 1'b1, 1'b0, 0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
